// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Round-robin two-master arbiter that decodes the winner's address
//            into a chip enable held for a per-region wait count, then pulses done.
// Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int unsigned WAIT0  = 2,
    parameter int unsigned WAIT1  = 3,
    parameter int unsigned WAITCS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic        req1,
    input  logic [31:0] addr1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] bus_addr,
    output logic        memce0,
    output logic        memce1,
    output logic        cs
);

    localparam logic [3:0] c_wait0  = WAIT0[3:0];
    localparam logic [3:0] c_wait1  = WAIT1[3:0];
    localparam logic [3:0] c_waitcs = WAITCS[3:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_last, w_last_nxt;
    logic [31:0] r_bus_addr, w_bus_addr_nxt;
    logic [1:0]  r_gnt, w_gnt_nxt;     // {gnt0, gnt1}
    logic [1:0]  r_done, w_done_nxt;   // {done0, done1}
    logic [2:0]  r_en, w_en_nxt;       // {memce0, memce1, cs}

    logic        w_win_valid;
    logic        w_win;
    logic [31:0] w_win_addr;
    logic [2:0]  w_win_en;
    logic [3:0]  w_win_wait;

    // On a tie the master that was not served last wins; r_last doubles as the current owner.
    assign w_win_valid = req0 | req1;
    assign w_win       = (req0 & req1) ? ~r_last : req1;
    assign w_win_addr  = w_win ? addr1 : addr0;

    always_comb begin
        w_win_en   = 3'b001;
        w_win_wait = c_waitcs;
        case (w_win_addr[31:30])
            2'b10: begin
                w_win_en   = 3'b100;
                w_win_wait = c_wait0;
            end
            2'b11: begin
                w_win_en   = 3'b010;
                w_win_wait = c_wait1;
            end
            default: begin
                w_win_en   = 3'b001;
                w_win_wait = c_waitcs;
            end
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_last_nxt     = r_last;
        w_bus_addr_nxt = r_bus_addr;
        w_gnt_nxt      = r_gnt;
        w_en_nxt       = r_en;
        w_done_nxt     = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (w_win_valid) begin
                    w_bus_addr_nxt = w_win_addr;
                    w_gnt_nxt      = w_win ? 2'b01 : 2'b10;
                    w_en_nxt       = w_win_en;
                    w_cnt_nxt      = w_win_wait;
                    w_last_nxt     = w_win;
                    w_state_nxt    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_gnt_nxt   = 2'b00;
                    w_en_nxt    = 3'b000;
                    w_done_nxt  = r_last ? 2'b01 : 2'b10;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_gnt_nxt   = 2'b00;
                w_en_nxt    = 3'b000;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_last     <= 1'b1;
            r_bus_addr <= 32'd0;
            r_gnt      <= 2'b00;
            r_done     <= 2'b00;
            r_en       <= 3'b000;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last     <= w_last_nxt;
            r_bus_addr <= w_bus_addr_nxt;
            r_gnt      <= w_gnt_nxt;
            r_done     <= w_done_nxt;
            r_en       <= w_en_nxt;
        end
    end

    assign gnt0     = r_gnt[1];
    assign gnt1     = r_gnt[0];
    assign done0    = r_done[1];
    assign done1    = r_done[0];
    assign bus_addr = r_bus_addr;
    assign memce0   = r_en[2];
    assign memce1   = r_en[1];
    assign cs       = r_en[0];

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Scoreboard bench: a transaction-level model predicts each access,
//            a negedge monitor pops and compares as the arbiter presents grants.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int W0  = 2;
    localparam int W1  = 3;
    localparam int WCS = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [31:0] addr0 = 32'd0;
    logic [31:0] addr1 = 32'd0;
    logic        gnt0, gnt1, done0, done1, memce0, memce1, cs;
    logic [31:0] bus_addr;

    mem_bus_arbiter #(.WAIT0(W0), .WAIT1(W1), .WAITCS(WCS)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .bus_addr(bus_addr), .memce0(memce0), .memce1(memce1), .cs(cs)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [2:0]  en;     // {memce0, memce1, cs}
        int          w;
        int          eg;     // clock edge on which the grant is taken
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    int   cyc = 0;
    int   free_edge = 0;
    int   last_srv = 1;

    function automatic exp_t predict(input int m, input logic [31:0] a, input int eg);
        exp_t e;
        e.m = m; e.addr = a; e.eg = eg;
        case (a[31:30])
            2'b10:   begin e.en = 3'b100; e.w = W0;  end
            2'b11:   begin e.en = 3'b010; e.w = W1;  end
            default: begin e.en = 3'b001; e.w = WCS; end
        endcase
        return e;
    endfunction

    // Reference model: an access occupies the bus for WAIT+3 edges, then the next tie goes round-robin.
    always @(posedge clk) begin
        int   win;
        exp_t e;
        cyc++;
        if (rst) begin
            sb.delete();
            free_edge = 0;
            last_srv  = 1;
        end else if (cyc >= free_edge && (req0 || req1)) begin
            if (req0 && req1) win = 1 - last_srv;
            else              win = req1 ? 1 : 0;
            e = predict(win, win ? addr1 : addr0, cyc);
            sb.push_back(e);
            last_srv  = win;
            free_edge = cyc + e.w + 3;
        end
    end

    bit   in_acc = 1'b0;
    exp_t cur;
    int   len = 0;

    always @(negedge clk) begin
        logic [2:0] en;
        int         gm;
        en = {memce0, memce1, cs};
        gm = gnt1 ? 1 : 0;
        if (rst) begin
            in_acc = 1'b0;
        end else begin
            chk("enable_onehot", (($countones(en) > 1) || (gnt0 && gnt1)) ? 32'd1 : 32'd0, 32'd0);
            if (in_acc) begin
                if (gnt0 || gnt1) begin
                    len++;
                    chk("held_enable", en, cur.en);
                    chk("held_bus_addr", bus_addr, cur.addr);
                    chk("held_grant", {gnt0, gnt1}, (cur.m != 0) ? 2'b01 : 2'b10);
                    chk("no_done_in_access", {done0, done1}, 0);
                end else begin
                    chk("enable_cycles", len, cur.w + 1);
                    chk("done_pulse", {done0, done1}, (cur.m != 0) ? 2'b01 : 2'b10);
                    chk("enable_off_at_done", en, 0);
                    in_acc = 1'b0;
                end
            end else if (gnt0 || gnt1) begin
                chk("grant_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                end else begin
                    cur.m = gm; cur.en = en; cur.addr = bus_addr; cur.w = 0; cur.eg = cyc;
                end
                chk("grant_master", gm, cur.m);
                chk("grant_bus_addr", bus_addr, cur.addr);
                chk("grant_enable", en, cur.en);
                chk("grant_cycle", cyc, cur.eg);
                glog.push_back(gm);
                in_acc = 1'b1;
                len    = 1;
            end else begin
                chk("idle_quiet", {done0, done1, en}, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return gnt0;
            1:       return gnt1;
            2:       return done0;
            default: return done1;
        endcase
    endfunction

    task automatic wait_sig(input int w, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (sig(w)) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    task automatic set_req(input int m, input logic v);
        if (m == 0) req0 = v; else req1 = v;
    endtask

    task automatic set_addr(input int m, input logic [31:0] a);
        if (m == 0) addr0 = a; else addr1 = a;
    endtask

    task automatic single(input int m, input logic [31:0] a);
        set_addr(m, a);
        set_req(m, 1'b1);
        wait_sig(m, "single_grant_timeout");
        wait_sig(m + 2, "single_done_timeout");
        set_req(m, 1'b0);
        repeat (3) step();
    endtask

    // Random requester: holds req until done, may move addr or drop req after the grant.
    task automatic drive(input int m, input int n);
        for (int t = 0; t < n; t++) begin
            if (!((m != 0) ? req1 : req0)) begin
                repeat ($urandom_range(0, 3)) step();
                set_addr(m, $urandom);
                set_req(m, 1'b1);
            end
            wait_sig(m, "rand_grant_timeout");
            case ($urandom_range(0, 3))
                0:       set_addr(m, $urandom);
                1:       set_req(m, 1'b0);
                default: ;
            endcase
            wait_sig(m + 2, "rand_done_timeout");
            if ($urandom_range(0, 2) == 0) set_addr(m, $urandom);
            else                           set_req(m, 1'b0);
        end
        set_req(m, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        step();
        chk("reset_outputs", {gnt0, gnt1, done0, done1, memce0, memce1, cs}, 0);
        chk("reset_bus_addr", bus_addr, 0);
        step();
        rst = 1'b0;
        step();

        single(0, 32'h8000_0000);
        single(1, 32'hC000_0010);
        single(0, 32'h4000_0000);
        single(0, 32'h0000_0004);

        // Both masters requesting continuously from reset.
        rst = 1'b1;
        set_addr(0, 32'h8000_0000); set_addr(1, 32'h8000_0000);
        set_req(0, 1'b1); set_req(1, 1'b1);
        step(); step();
        rst  = 1'b0;
        base = glog.size();
        for (int i = 0; i < 100 && glog.size() < base + 4; i++) step();
        set_req(0, 1'b0); set_req(1, 1'b0);
        chk("rr_grant_count", (glog.size() >= base + 4) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 4; i++)
            chk("rr_order", (glog.size() > base + i) ? glog[base + i] : -1, i % 2);
        repeat (10) step();

        // Reset during the second memce0 cycle.
        set_addr(0, 32'h8000_0000);
        set_req(0, 1'b1);
        wait_sig(0, "mr_grant_timeout");
        step();
        chk("mr_second_cycle", memce0, 1);
        rst = 1'b1;
        set_addr(1, 32'h0000_0100);
        set_req(1, 1'b1);
        #1;
        chk("async_reset_outputs", {gnt0, gnt1, done0, done1, memce0, memce1, cs}, 0);
        chk("async_reset_bus_addr", bus_addr, 0);
        step(); step();
        rst  = 1'b0;
        base = glog.size();
        wait_sig(2, "mr_done0_timeout");
        set_req(0, 1'b0);
        chk("mr_first_grant", (glog.size() > base) ? glog[base] : -1, 0);
        wait_sig(3, "mr_done1_timeout");
        set_req(1, 1'b0);
        repeat (4) step();

        // Drop req0 on the first access cycle and move addr0.
        set_addr(0, 32'h8000_0000);
        set_req(0, 1'b1);
        wait_sig(0, "drop_grant_timeout");
        set_req(0, 1'b0);
        set_addr(0, 32'hC000_0000);
        wait_sig(2, "drop_done_timeout");
        base = glog.size();
        repeat (8) step();
        chk("no_regrant", glog.size(), base);

        fork
            drive(0, 40);
            drive(1, 40);
        join

        repeat (30) step();
        chk("scoreboard_empty", sb.size(), 0);
        chk("access_closed", in_acc, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
